// File: rtl/pid_secuenciador.sv
// pid_secuenciador: time-multiplexed PID controller.
// A single signed multiplier and accumulator evaluate the P, I and D terms
// on three consecutive cycles after each accepted sample strobe. The sum is
// then registered as the control output.
// Optional build macro: PID_SAT_EN. When it is defined, the output saturates
// and the integrator clamps (anti-windup). When it is undefined, both wrap.
module pid_secuenciador #(
   parameter int unsigned W    = 19,
   parameter int unsigned FRAC = 8
) (
   input  logic                CLK,
   input  logic                Reset,
   input  logic                Start,
   input  logic signed [W-1:0] e,
   input  logic signed [W-1:0] Kp,
   input  logic signed [W-1:0] Ki,
   input  logic signed [W-1:0] Kd,
   output logic signed [W-1:0] u,
   output logic                Busy,
   output logic                Done
);

   localparam int unsigned AW = W + 3;   // accumulator
   localparam int unsigned IW = W + 4;   // integrator
   localparam int unsigned DW = W + 1;   // error difference
   localparam int unsigned BW = W + 4;   // multiplier operand B (widest: integrator)
   localparam int unsigned PW = W + BW;  // full-precision product
`ifdef PID_SAT_EN
   localparam int unsigned SW = AW + 1;  // output pre-fit sum
`endif

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      MUL_P = 2'd1,
      MUL_I = 2'd2,
      MUL_D = 2'd3
   } state_t;

   state_t state_q, state_d;

   logic signed [W-1:0]  e_cur_q, e_cur_d;
   logic signed [W-1:0]  e_prev_q, e_prev_d;
   logic signed [IW-1:0] integ_q, integ_d;
   logic signed [AW-1:0] acc_q, acc_d;
   logic signed [W-1:0]  u_d;
   logic                 done_d;
   logic                 busy_d;

   logic signed [DW-1:0] diff;
   logic signed [IW-1:0] integ_n;
   logic signed [W-1:0]  mul_a;
   logic signed [BW-1:0] mul_b;
   logic signed [PW-1:0] prod;
   logic signed [AW-1:0] term;
   logic signed [W-1:0]  fit_out;
`ifdef PID_SAT_EN
   logic signed [IW-1:0] integ_sum;
   logic signed [SW-1:0] out_sum;
`endif

   // Datapath: error difference, next integrator value, shared multiplier and output fit
   always_comb begin
      diff = DW'(e_cur_q) - DW'(e_prev_q);

`ifdef PID_SAT_EN
      integ_sum = integ_q + IW'(e_cur_q);
      if (!integ_sum[IW-1] && (|integ_sum[IW-1:W-1])) begin
         integ_n = {{(IW-W+1){1'b0}}, {(W-1){1'b1}}};
      end else if (integ_sum[IW-1] && !(&integ_sum[IW-1:W-1])) begin
         integ_n = {{(IW-W+1){1'b1}}, {(W-1){1'b0}}};
      end else begin
         integ_n = integ_sum;
      end
`else
      integ_n = integ_q + IW'(e_cur_q);
`endif

      mul_a = '0;
      mul_b = '0;
      case (state_q)
         MUL_P: begin
            mul_a = Kp;
            mul_b = BW'(e_cur_q);
         end
         MUL_I: begin
            mul_a = Ki;
            mul_b = integ_n;
         end
         MUL_D: begin
            mul_a = Kd;
            mul_b = BW'(diff);
         end
         default: begin
            mul_a = '0;
            mul_b = '0;
         end
      endcase

      prod = PW'(mul_a) * PW'(mul_b);
      term = AW'(prod >>> FRAC);

`ifdef PID_SAT_EN
      out_sum = SW'(acc_q) + SW'(term);
      if (!out_sum[SW-1] && (|out_sum[SW-1:W-1])) begin
         fit_out = {1'b0, {(W-1){1'b1}}};
      end else if (out_sum[SW-1] && !(&out_sum[SW-1:W-1])) begin
         fit_out = {1'b1, {(W-1){1'b0}}};
      end else begin
         fit_out = out_sum[W-1:0];
      end
`else
      fit_out = W'(acc_q + term);
`endif
   end

   // Next-state and register-update decode for the IDLE -> P -> I -> D sequence
   always_comb begin
      state_d  = state_q;
      e_cur_d  = e_cur_q;
      e_prev_d = e_prev_q;
      integ_d  = integ_q;
      acc_d    = acc_q;
      u_d      = u;
      done_d   = 1'b0;

      case (state_q)
         IDLE: begin
            if (Start) begin
               e_cur_d = e;
               state_d = MUL_P;
            end
         end
         MUL_P: begin
            acc_d   = term;
            state_d = MUL_I;
         end
         MUL_I: begin
            integ_d = integ_n;
            acc_d   = acc_q + term;
            state_d = MUL_D;
         end
         MUL_D: begin
            u_d      = fit_out;
            e_prev_d = e_cur_q;
            done_d   = 1'b1;
            state_d  = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   // State and datapath registers; reset aborts any sequence in flight
   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         state_q  <= IDLE;
         e_cur_q  <= '0;
         e_prev_q <= '0;
         integ_q  <= '0;
         acc_q    <= '0;
         u        <= '0;
         Done     <= 1'b0;
         Busy     <= 1'b0;
      end else begin
         state_q  <= state_d;
         e_cur_q  <= e_cur_d;
         e_prev_q <= e_prev_d;
         integ_q  <= integ_d;
         acc_q    <= acc_d;
         u        <= u_d;
         Done     <= done_d;
         Busy     <= busy_d;
      end
   end

endmodule

// File: tb/tb_pid_secuenciador.sv
// Self-checking bench for pid_secuenciador with a behavioural PID model.
module tb_pid_secuenciador;

   localparam int unsigned W    = 19;
   localparam int unsigned FRAC = 8;

   logic                CLK = 1'b0;
   logic                Reset;
   logic                Start;
   logic signed [W-1:0] e, Kp, Ki, Kd;
   logic signed [W-1:0] u;
   logic                Busy, Done;

   int n_cmp = 0;
   int n_err = 0;

   longint m_integ = 0;
   longint m_eprev = 0;

   pid_secuenciador #(.W(W), .FRAC(FRAC)) dut (
      .CLK(CLK), .Reset(Reset), .Start(Start), .e(e),
      .Kp(Kp), .Ki(Ki), .Kd(Kd), .u(u), .Busy(Busy), .Done(Done)
   );

   always #5 CLK = ~CLK;

   // Reduce x to an n-bit two's-complement value
   function automatic longint wrap(longint x, int n);
      longint span = longint'(1) << n;
      longint r    = x & (span - 1);
      if (r >= (span >>> 1)) r = r - span;
      return r;
   endfunction

   function automatic longint clamp(longint x, int n);
      longint hi = (longint'(1) << (n - 1)) - 1;
      longint lo = -(longint'(1) << (n - 1));
      if (x > hi) return hi;
      if (x < lo) return lo;
      return x;
   endfunction

   // One controller sample computed from the arithmetic definition
   function automatic longint model_step(longint ev, longint kp, longint ki, longint kd);
      longint integ_n, pterm, iterm, dterm, acc, res;
`ifdef PID_SAT_EN
      integ_n = clamp(m_integ + ev, W);
`else
      integ_n = wrap(m_integ + ev, W + 4);
`endif
      pterm = wrap((kp * ev) >>> FRAC, W + 3);
      iterm = wrap((ki * integ_n) >>> FRAC, W + 3);
      acc   = wrap(pterm + iterm, W + 3);
      dterm = wrap((kd * (ev - m_eprev)) >>> FRAC, W + 3);
`ifdef PID_SAT_EN
      res = clamp(acc + dterm, W);
`else
      res = wrap(acc + dterm, W);
`endif
      m_integ = integ_n;
      m_eprev = ev;
      return res;
   endfunction

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic do_reset();
      Start = 1'b0;
      Reset = 1'b0;
      repeat (2) tick();
      Reset = 1'b1;
      tick();
      m_integ = 0;
      m_eprev = 0;
   endtask

   // Pulse Start with error ev and wait (bounded) for Done; lat = edges to Done or -1
   task automatic do_sample(input logic signed [W-1:0] ev, output int lat);
      e     = ev;
      Start = 1'b1;
      tick();
      Start = 1'b0;
      lat   = 1;
      while (!Done && lat < 10) begin
         tick();
         lat++;
      end
      if (!Done) lat = -1;
   endtask

   task automatic test_reset();
      Kp = '0; Ki = '0; Kd = '0; e = '0;
      do_reset();
      n_cmp++;
      if (u !== '0 || Busy !== 1'b0 || Done !== 1'b0) begin
         n_err++;
         $display("FAIL reset: u=%0d Busy=%b Done=%b, expected 0/0/0", u, Busy, Done);
      end
   endtask

   task automatic test_proportional();
      longint exp_u;
      do_reset();
      Kp = 19'sd256; Ki = '0; Kd = '0;
      exp_u = model_step(100, 256, 0, 0);
      e = 19'sd100;
      Start = 1'b1;
      tick();
      Start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         n_cmp++;
         if (Busy !== 1'b1 || Done !== 1'b0) begin
            n_err++;
            $display("FAIL prop_busy[%0d]: Busy=%b Done=%b, expected 1/0", i, Busy, Done);
         end
         if (i < 2) tick();
      end
      tick();
      n_cmp++;
      if (Done !== 1'b1 || Busy !== 1'b0) begin
         n_err++;
         $display("FAIL prop_done: Done=%b Busy=%b, expected 1/0", Done, Busy);
      end
      n_cmp++;
      if (longint'(u) != 100 || longint'(u) != exp_u) begin
         n_err++;
         $display("FAIL prop_u: u=%0d, expected 100 (model %0d)", u, exp_u);
      end
      tick();
      n_cmp++;
      if (Done !== 1'b0 || longint'(u) != 100) begin
         n_err++;
         $display("FAIL prop_hold: Done=%b u=%0d, expected 0/100", Done, u);
      end
   endtask

   task automatic test_integrator();
      int lat;
      longint exp_u;
      do_reset();
      Kp = '0; Ki = 19'sd256; Kd = '0;
      for (int i = 1; i <= 3; i++) begin
         exp_u = model_step(10, 0, 256, 0);
         do_sample(19'sd10, lat);
         n_cmp++;
         if (lat != 4 || longint'(u) != 10 * i || longint'(u) != exp_u) begin
            n_err++;
            $display("FAIL integ[%0d]: lat=%0d u=%0d, expected 4/%0d", i, lat, u, 10 * i);
         end
         repeat (2) tick();
      end
   endtask

   task automatic test_derivative();
      int lat;
      longint exp_u;
      do_reset();
      Kp = '0; Ki = '0; Kd = 19'sd512;
      exp_u = model_step(5, 0, 0, 512);
      do_sample(19'sd5, lat);
      n_cmp++;
      if (lat != 4 || longint'(u) != 10 || longint'(u) != exp_u) begin
         n_err++;
         $display("FAIL deriv_first: lat=%0d u=%0d, expected 4/10", lat, u);
      end
      tick();
      exp_u = model_step(8, 0, 0, 512);
      do_sample(19'sd8, lat);
      n_cmp++;
      if (lat != 4 || longint'(u) != 6 || longint'(u) != exp_u) begin
         n_err++;
         $display("FAIL deriv_second: lat=%0d u=%0d, expected 4/6", lat, u);
      end
   endtask

   task automatic test_overflow();
      int lat;
      longint exp_u, spec_u;
`ifdef PID_SAT_EN
      spec_u = 262143;
`else
      spec_u = -48576;
`endif
      do_reset();
      Kp = 19'sd25600; Ki = '0; Kd = '0;
      exp_u = model_step(10000, 25600, 0, 0);
      do_sample(19'sd10000, lat);
      n_cmp++;
      if (lat != 4 || longint'(u) != spec_u || longint'(u) != exp_u) begin
         n_err++;
         $display("FAIL overflow: lat=%0d u=%0d, expected 4/%0d", lat, u, spec_u);
      end
   endtask

   task automatic test_handshake();
      int done_cnt = 0;
      int last_done = -100;
      do_reset();
      Kp = 19'sd256; Ki = '0; Kd = '0;
      e = 19'sd7;
      Start = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (Done) begin
            void'(model_step(7, 256, 0, 0));
            n_cmp++;
            if (i - last_done < 4 && last_done >= 0 || longint'(u) != 7) begin
               n_err++;
               $display("FAIL hs_done[%0d]: gap=%0d u=%0d, expected gap 4 u 7", i, i - last_done, u);
            end
            last_done = i;
            done_cnt++;
         end
      end
      Start = 1'b0;
      n_cmp++;
      if (done_cnt != 5) begin
         n_err++;
         $display("FAIL hs_count: %0d Done pulses, expected 5", done_cnt);
      end
      repeat (4) tick();
   endtask

   task automatic test_back_to_back();
      int lat;
      int extra = 0;
      longint exp_u;
      do_reset();
      Kp = 19'sd256; Ki = 19'sd256; Kd = 19'sd256;
      exp_u = model_step(30, 256, 256, 256);
      e = 19'sd30;
      Start = 1'b1;
      tick();
      e = 19'sd999;
      lat = 1;
      while (!Done && lat < 10) begin
         tick();
         lat++;
      end
      Start = 1'b0;
      n_cmp++;
      if (lat != 4 || longint'(u) != exp_u) begin
         n_err++;
         $display("FAIL busy_ignore: lat=%0d u=%0d, expected 4/%0d", lat, u, exp_u);
      end
      for (int i = 0; i < 6; i++) begin
         tick();
         if (Done || Busy) extra++;
      end
      n_cmp++;
      if (extra != 0) begin
         n_err++;
         $display("FAIL busy_queue: %0d busy/done cycles, expected 0", extra);
      end
      exp_u = model_step(30, 256, 256, 256);
      do_sample(19'sd30, lat);
      n_cmp++;
      if (lat != 4 || longint'(u) != exp_u) begin
         n_err++;
         $display("FAIL busy_integ: lat=%0d u=%0d, expected 4/%0d", lat, u, exp_u);
      end
   endtask

   task automatic test_reset_mid();
      int lat;
      int spurious = 0;
      do_reset();
      Kp = 19'sd256; Ki = 19'sd256; Kd = '0;
      do_sample(19'sd50, lat);
      tick();
      e = 19'sd20;
      Start = 1'b1;
      tick();
      Start = 1'b0;
      tick();
      Reset = 1'b0;
      #1;
      n_cmp++;
      if (Busy !== 1'b0 || Done !== 1'b0 || u !== '0) begin
         n_err++;
         $display("FAIL rst_mid: Busy=%b Done=%b u=%0d, expected 0/0/0", Busy, Done, u);
      end
      tick();
      Reset = 1'b1;
      m_integ = 0;
      m_eprev = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (Done || Busy) spurious++;
      end
      n_cmp++;
      if (spurious != 0) begin
         n_err++;
         $display("FAIL rst_idle: %0d busy/done cycles, expected 0", spurious);
      end
      Kp = '0;
      void'(model_step(10, 0, 256, 0));
      do_sample(19'sd10, lat);
      n_cmp++;
      if (lat != 4 || longint'(u) != 10) begin
         n_err++;
         $display("FAIL rst_integ: lat=%0d u=%0d, expected 4/10", lat, u);
      end
   endtask

   task automatic test_random();
      int lat;
      longint exp_u;
      logic signed [W-1:0] ev;
      do_reset();
      for (int i = 0; i < 40; i++) begin
         Kp = W'($urandom);
         Ki = W'($urandom);
         Kd = W'($urandom);
         ev = W'($urandom);
         exp_u = model_step(longint'(ev), longint'(Kp), longint'(Ki), longint'(Kd));
         do_sample(ev, lat);
         n_cmp++;
         if (lat != 4 || longint'(u) != exp_u) begin
            n_err++;
            $display("FAIL random[%0d]: lat=%0d u=%0d, expected 4/%0d", i, lat, u, exp_u);
         end
         repeat ($urandom_range(0, 3)) tick();
      end
   endtask

   initial begin
      Reset = 1'b0;
      Start = 1'b0;
      e = '0; Kp = '0; Ki = '0; Kd = '0;
      test_reset();
      test_proportional();
      test_integrator();
      test_derivative();
      test_overflow();
      test_handshake();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
